// File: rtl/modular_inverse_pkg.sv
// Shared definitions for the ECC arithmetic sequencers: FSM state encoding
// and the default operand width.
package modular_inverse_pkg;

  localparam int unsigned default_n = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/modular_inverse_if.sv
// Start/result handshake between a sequencer (master) and the modular
// inverse engine (slave).
interface modular_inverse_if
  import modular_inverse_pkg::*;
#(
  parameter int n = default_n
);

  logic         start;
  logic [n-1:0] p;
  logic [n-1:0] a;
  logic [n-1:0] inv;
  logic         result;
  logic         no_inverse;

  modport master (
    output start, p, a,
    input  inv, result, no_inverse
  );

  modport slave (
    input  start, p, a,
    output inv, result, no_inverse
  );

endinterface

// File: rtl/modular_inverse_mod_half.sv
// Modular halving: x/2 mod m for x in [0,m) and odd m, purely combinational.
module mod_half #(
  parameter int n = 8
) (
  input  logic [n:0]   x,
  input  logic [n-1:0] mod,
  output logic [n:0]   half
);

  localparam int w = n + 1;

  // Odd x with odd m gives an even x+m; one extra bit keeps the carry.
  logic [n+1:0] sum;

  assign sum  = {1'b0, x} + {2'b00, mod};
  assign half = x[0] ? w'(sum >> 1) : (x >> 1);

endmodule

// File: rtl/modular_inverse.sv
// Iterative binary extended Euclid: inv = a^-1 mod p, one step per clock,
// with a step-count guard that forces DONE/no_inverse on bad operands.
module modular_inverse
  import modular_inverse_pkg::*;
#(
  parameter int n = default_n
) (
  input  logic              clk,
  input  logic              reset,
  modular_inverse_if.slave  bus
);

  localparam int w         = n + 1;
  localparam int max_steps = 4 * n + 2;
  localparam int cw        = $clog2(4 * n + 3);

  localparam logic [n-1:0]  one_n    = n'(1);
  localparam logic [w-1:0]  one_w    = w'(1);
  localparam logic [cw-1:0] one_c    = cw'(1);
  localparam logic [cw-1:0] last_cnt = cw'(max_steps - 1);

  state_t        state;
  logic [n-1:0]  u, v, mod;
  logic [n:0]    x1, x2;
  logic [cw-1:0] cnt;
  logic [n-1:0]  inv_q;
  logic          result_q, no_inverse_q;

  logic [n:0]    x1_half, x2_half;
  logic [n:0]    x1_minus_x2, x2_minus_x1;

  mod_half #(.n(n)) u_half_x1 (.x(x1), .mod(mod), .half(x1_half));
  mod_half #(.n(n)) u_half_x2 (.x(x2), .mod(mod), .half(x2_half));

  // Both operands lie in [0,p), so x+p-y never leaves n+1 bits.
  always_comb begin
    x1_minus_x2 = (x1 >= x2) ? (x1 - x2) : (x1 + {1'b0, mod} - x2);
    x2_minus_x1 = (x2 >= x1) ? (x2 - x1) : (x2 + {1'b0, mod} - x1);
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others within the same step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      u            <= '0;
      v            <= '0;
      mod          <= '0;
      x1           <= '0;
      x2           <= '0;
      cnt          <= '0;
      inv_q        <= '0;
      result_q     <= 1'b0;
      no_inverse_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            inv_q        <= '0;
            result_q     <= 1'b0;
            no_inverse_q <= 1'b0;
            u            <= bus.a;
            v            <= bus.p;
            mod          <= bus.p;
            x1           <= one_w;
            x2           <= '0;
            cnt          <= '0;
            if (bus.a == '0) begin
              state        <= DONE;
              result_q     <= 1'b1;
              no_inverse_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          cnt <= cnt + one_c;
          if (u == one_n) begin
            inv_q    <= x1[n-1:0];
            result_q <= 1'b1;
            state    <= DONE;
          end else if (v == one_n) begin
            inv_q    <= x2[n-1:0];
            result_q <= 1'b1;
            state    <= DONE;
          end else if (u == '0 || v == '0 || cnt == last_cnt) begin
            // gcd(a,p) != 1, or the step budget ran out on illegal operands.
            inv_q        <= '0;
            result_q     <= 1'b1;
            no_inverse_q <= 1'b1;
            state        <= DONE;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= x1_minus_x2;
          end else begin
            v  <= v - u;
            x2 <= x2_minus_x1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inv        = inv_q;
  assign bus.result     = result_q;
  assign bus.no_inverse = no_inverse_q;

endmodule

// File: tb/tb_modular_inverse.sv
// Self-checking bench for modular_inverse: brute-force inverse model plus
// directed vectors with hand-computed results and latencies.
module tb_modular_inverse;

  localparam int n         = 8;
  localparam int max_steps = 4 * n + 2;

  logic clk;
  logic reset;

  modular_inverse_if #(.n(n)) bus ();

  modular_inverse #(.n(n)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model expectations for the operation currently in flight.
  bit chk_en    = 1'b0;
  int exp_inv   = 0;
  int exp_noinv = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inverse by exhaustive search: 0 when none exists.
  function automatic int model_inv(input int pp, input int aa);
    for (int i = 1; i < pp; i++)
      if ((aa * i) % pp == 1) return i;
    return 0;
  endfunction

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (chk_en && !reset && bus.result) begin
      check("model_inv", 32'(bus.inv), exp_inv);
      check("model_no_inverse", 32'(bus.no_inverse), exp_noinv);
    end
  end

  task automatic do_start(input int pp, input int aa);
    bus.p     = 8'(pp);
    bus.a     = 8'(aa);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    exp_inv   = model_inv(pp, aa);
    exp_noinv = (exp_inv == 0) ? 1 : 0;
    chk_en    = 1'b1;
    if (aa != 0) check("result_cleared_on_start", 32'(bus.result), 0);
  endtask

  // Edges counted after the accepting edge until result is high.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.result && lat < max_steps + 6) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_within_bound", (lat <= max_steps) ? 32'd1 : 32'd0, 1);
  endtask

  initial begin
    int lat;
    int lat2;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.p     = '0;
    bus.a     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 32'(bus.result), 0);
    check("reset_no_inverse", 32'(bus.no_inverse), 0);
    check("reset_inv", 32'(bus.inv), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // p=17, a=12: seven steps then the v==1 action.
    do_start(17, 12);
    wait_result(lat);
    check("lat_17_12", lat, 8);
    check("inv_17_12", 32'(bus.inv), 10);
    check("noinv_17_12", 32'(bus.no_inverse), 0);
    repeat (20) @(posedge clk);
    #1;
    check("hold_result", 32'(bus.result), 1);
    check("hold_inv", 32'(bus.inv), 10);

    do_start(17, 1);
    wait_result(lat);
    check("lat_17_1", lat, 1);
    check("inv_17_1", 32'(bus.inv), 1);

    do_start(17, 16);
    wait_result(lat);
    check("inv_17_16", 32'(bus.inv), 16);

    for (int i = 1; i < 17; i++) begin
      do_start(17, i);
      wait_result(lat);
      check("exh_product", (i * int'(bus.inv)) % 17, 1);
      check("exh_noinv", 32'(bus.no_inverse), 0);
    end

    // a=0: DONE straight from the accepting edge.
    do_start(17, 0);
    check("zero_result", 32'(bus.result), 1);
    check("zero_no_inverse", 32'(bus.no_inverse), 1);
    check("zero_inv", 32'(bus.inv), 0);

    // Composite modulus sharing a factor with a.
    do_start(15, 6);
    wait_result(lat);
    check("p15_result", 32'(bus.result), 1);
    check("p15_no_inverse", 32'(bus.no_inverse), 1);
    check("p15_inv", 32'(bus.inv), 0);

    // Reset lands on RUN cycle 3 alongside a start that must be ignored.
    do_start(251, 7);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en    = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'd2;
    @(posedge clk);
    #1;
    check("midrun_reset_result", 32'(bus.result), 0);
    check("midrun_reset_noinv", 32'(bus.no_inverse), 0);
    check("midrun_reset_inv", 32'(bus.inv), 0);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("start_during_reset_ignored", 32'(bus.result), 0);

    do_start(251, 2);
    wait_result(lat);
    check("lat_251_2", lat, 2);
    check("inv_251_2", 32'(bus.inv), 126);

    chk_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    check("done_reset_result", 32'(bus.result), 0);
    check("done_reset_inv", 32'(bus.inv), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Start pulse at RUN cycle 4 with a new operand is ignored.
    do_start(17, 12);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_result(lat2);
    check("ignored_start_latency", 4 + lat2, 8);
    check("ignored_start_inv", 32'(bus.inv), 10);

    // Restart directly from DONE.
    do_start(17, 3);
    wait_result(lat);
    check("lat_17_3", lat, 6);
    check("inv_17_3", 32'(bus.inv), 6);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
